// File: rtl/savior_pkg.sv
// Shared types and constants for the savior movement controller.
// Direction/edge helpers keep the wall and key bit mappings in one place.
package savior_pkg;

  typedef enum logic [2:0] {DIR_NONE, DIR_R, DIR_L, DIR_U, DIR_D} dir_t;
  typedef enum logic [1:0] {IDLE, MOVE, BLOCKED} state_t;

  localparam int EDGE_L = 3;
  localparam int EDGE_T = 2;
  localparam int EDGE_R = 1;
  localparam int EDGE_B = 0;

  localparam int FIXED_POINT_MULTIPLIER = 64;

  // Edge of the savior that faces the wall when moving in direction d.
  function automatic logic [1:0] edge_of(dir_t d);
    case (d)
      DIR_L:   return 2'(EDGE_L);
      DIR_U:   return 2'(EDGE_T);
      DIR_R:   return 2'(EDGE_R);
      default: return 2'(EDGE_B);
    endcase
  endfunction

  // stopKeySignal bit that blocks direction d (key-side wall encoding).
  function automatic logic [1:0] key_bit_of(dir_t d);
    case (d)
      DIR_L:   return 2'd1;
      DIR_R:   return 2'd3;
      DIR_U:   return 2'd0;
      default: return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/savior_speed_ramp.sv
// Frame-enabled saturating speed ramp: load to min, step up to max, or drop to zero.
// speed_d_o exposes the value that will be registered so position can use it in the same frame.
module savior_speed_ramp #(
  parameter int SPEED_MIN  = 64,
  parameter int SPEED_STEP = 16,
  parameter int SPEED_MAX  = 192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic        step_i,
  output logic [10:0] speed_d_o,
  output logic [10:0] speed_q_o
);

  logic [10:0] speed_q;
  logic [10:0] speed_d;
  logic [11:0] sum;

  always_comb begin
    sum     = {1'b0, speed_q} + 12'(SPEED_STEP);
    speed_d = speed_q;
    if (en_i) begin
      if (load_i)      speed_d = 11'(SPEED_MIN);
      else if (step_i) speed_d = (sum > 12'(SPEED_MAX)) ? 11'(SPEED_MAX) : sum[10:0];
      else             speed_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) speed_q <= '0;
    else                  speed_q <= speed_d;
  end

  assign speed_d_o = speed_d;
  assign speed_q_o = speed_q;

endmodule

// File: rtl/savior_move_ctrl.sv
// Savior motion controller: buttons -> direction, accelerating speed and fixed-point position,
// honouring key stop requests and reporting wall blocks back to the key.
module savior_move_ctrl
  import savior_pkg::*;
#(
  parameter int SPEED_MIN  = 64,
  parameter int SPEED_STEP = 16,
  parameter int SPEED_MAX  = 192,
  parameter int BACKOFF    = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               btnRight,
  input  logic               btnLeft,
  input  logic               btnUp,
  input  logic               btnDown,
  input  logic               collisionSavBorder,
  input  logic [3:0]         HitEdgeCode,
  input  logic [3:0]         stopKeySignal,
  input  logic [10:0]        INITIAL_X,
  input  logic [10:0]        INITIAL_Y,
  input  logic               startLevel2,
  input  logic               startLevel3,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               moveRightSav,
  output logic               moveLeftSav,
  output logic               moveUpSav,
  output logic [10:0]        XspeedSav,
  output logic [10:0]        YspeedSav,
  output logic [3:0]         stopSaviorSignal,
  output state_t             state_dbg_o
);

  localparam int FP_SHIFT = $clog2(FIXED_POINT_MULTIPLIER);

  state_t      state_q;
  dir_t        dir_q, sel_dir;
  logic        hit_q;
  logic [3:0]  stop_q;
  int          x_q, y_q;
  logic        restart, same_dir, hit_now, key_blk, ramp_load, ramp_step;
  logic [10:0] speed_d, speed_q;
  int          spd, mv_x, mv_y, bo_x, bo_y;

  assign restart = reset | startLevel2 | startLevel3;

  always_comb begin
    sel_dir = DIR_NONE;
    if (btnRight)     sel_dir = DIR_R;
    else if (btnLeft) sel_dir = DIR_L;
    else if (btnUp)   sel_dir = DIR_U;
    else if (btnDown) sel_dir = DIR_D;
  end

  assign same_dir  = (sel_dir == dir_q);
  assign hit_now   = collisionSavBorder && (dir_q != DIR_NONE) && HitEdgeCode[edge_of(dir_q)];
  assign key_blk   = (sel_dir != DIR_NONE) && stopKeySignal[key_bit_of(sel_dir)];
  assign ramp_load = (sel_dir != DIR_NONE) && !same_dir && !key_blk;
  assign ramp_step = (sel_dir != DIR_NONE) && same_dir && (state_q == MOVE) && !hit_q && !key_blk;

  savior_speed_ramp #(
    .SPEED_MIN (SPEED_MIN),
    .SPEED_STEP(SPEED_STEP),
    .SPEED_MAX (SPEED_MAX)
  ) u_ramp (
    .clk      (clk),
    .reset    (reset),
    .en_i     (startOfFrame),
    .clear_i  (restart),
    .load_i   (ramp_load),
    .step_i   (ramp_step),
    .speed_d_o(speed_d),
    .speed_q_o(speed_q)
  );

  // Movement uses this frame's new speed; backoff pushes away from the wall just hit.
  always_comb begin
    spd  = int'(speed_d);
    mv_x = 0;
    mv_y = 0;
    bo_x = 0;
    bo_y = 0;
    case (sel_dir)
      DIR_R:   mv_x = spd;
      DIR_L:   mv_x = -spd;
      DIR_U:   mv_y = -spd;
      DIR_D:   mv_y = spd;
      default: ;
    endcase
    case (dir_q)
      DIR_R:   bo_x = -BACKOFF;
      DIR_L:   bo_x = BACKOFF;
      DIR_U:   bo_y = BACKOFF;
      DIR_D:   bo_y = -BACKOFF;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      state_q <= IDLE;
      dir_q   <= DIR_NONE;
      hit_q   <= 1'b0;
      stop_q  <= '0;
      x_q     <= int'(INITIAL_X) * FIXED_POINT_MULTIPLIER;
      y_q     <= int'(INITIAL_Y) * FIXED_POINT_MULTIPLIER;
    end else begin
      if (hit_now) hit_q <= 1'b1;
      if (startOfFrame) begin
        dir_q <= sel_dir;
        if (sel_dir == DIR_NONE) begin
          state_q <= IDLE;
          hit_q   <= 1'b0;
          stop_q  <= '0;
        end else if (!same_dir) begin
          hit_q  <= 1'b0;
          stop_q <= '0;
          if (key_blk) begin
            state_q <= BLOCKED;
          end else begin
            state_q <= MOVE;
            x_q     <= x_q + mv_x;
            y_q     <= y_q + mv_y;
          end
        end else if (state_q == MOVE) begin
          if (hit_q) begin
            state_q                 <= BLOCKED;
            stop_q[edge_of(dir_q)] <= 1'b1;
            x_q                     <= x_q + bo_x;
            y_q                     <= y_q + bo_y;
          end else if (key_blk) begin
            state_q <= BLOCKED;
          end else begin
            x_q <= x_q + mv_x;
            y_q <= y_q + mv_y;
          end
        end
      end
    end
  end

  // Pixel = fixed point / multiplier, truncating toward zero.
  function automatic logic [10:0] to_pixel(int p);
    int q;
    q = (p < 0) ? -((-p) >>> FP_SHIFT) : (p >>> FP_SHIFT);
    return q[10:0];
  endfunction

  assign topLeftX         = to_pixel(x_q);
  assign topLeftY         = to_pixel(y_q);
  assign moveRightSav     = (dir_q != DIR_R);
  assign moveLeftSav      = !((dir_q == DIR_L) || (dir_q == DIR_D));
  assign moveUpSav        = !((dir_q == DIR_U) || (dir_q == DIR_D));
  assign XspeedSav        = ((dir_q == DIR_R) || (dir_q == DIR_L)) ? speed_q : '0;
  assign YspeedSav        = ((dir_q == DIR_U) || (dir_q == DIR_D)) ? speed_q : '0;
  assign stopSaviorSignal = stop_q;
  assign state_dbg_o      = state_q;

endmodule

// File: tb/tb_savior_move_ctrl.sv
// Directed bench for savior_move_ctrl: each frame pushes its expected outputs,
// a monitor compares them one cycle after every startOfFrame or check request.
module tb_savior_move_ctrl;
  import savior_pkg::*;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [2:0]  flg;
    logic [10:0] xs;
    logic [10:0] ys;
    logic [3:0]  stp;
    logic [1:0]  st;
  } obs_t;
  localparam int W = $bits(obs_t);

  localparam logic [2:0] F_NONE = 3'b111;
  localparam logic [2:0] F_R    = 3'b011;
  localparam logic [2:0] F_L    = 3'b101;
  localparam logic [2:0] F_U    = 3'b110;
  localparam logic [2:0] F_D    = 3'b100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic startOfFrame = 1'b0;
  logic btnRight = 1'b0, btnLeft = 1'b0, btnUp = 1'b0, btnDown = 1'b0;
  logic collisionSavBorder = 1'b0;
  logic [3:0] HitEdgeCode = '0;
  logic [3:0] stopKeySignal = '0;
  logic [10:0] INITIAL_X = 11'd100;
  logic [10:0] INITIAL_Y = 11'd200;
  logic startLevel2 = 1'b0, startLevel3 = 1'b0;
  logic signed [10:0] topLeftX, topLeftY;
  logic moveRightSav, moveLeftSav, moveUpSav;
  logic [10:0] XspeedSav, YspeedSav;
  logic [3:0] stopSaviorSignal;
  state_t state_dbg_o;

  logic chk_req = 1'b0;
  logic obs_q = 1'b0;
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  savior_move_ctrl dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .btnRight(btnRight), .btnLeft(btnLeft), .btnUp(btnUp), .btnDown(btnDown),
    .collisionSavBorder(collisionSavBorder), .HitEdgeCode(HitEdgeCode),
    .stopKeySignal(stopKeySignal), .INITIAL_X(INITIAL_X), .INITIAL_Y(INITIAL_Y),
    .startLevel2(startLevel2), .startLevel3(startLevel3),
    .topLeftX(topLeftX), .topLeftY(topLeftY),
    .moveRightSav(moveRightSav), .moveLeftSav(moveLeftSav), .moveUpSav(moveUpSav),
    .XspeedSav(XspeedSav), .YspeedSav(YspeedSav),
    .stopSaviorSignal(stopSaviorSignal), .state_dbg_o(state_dbg_o)
  );

  // clock / observation strobe
  always #5 clk = ~clk;
  always @(posedge clk) obs_q <= startOfFrame | chk_req;

  // monitor / scoreboard
  always @(negedge clk) begin
    if (obs_q) begin
      obs_t act, e;
      act = {topLeftX, topLeftY, {moveRightSav, moveLeftSav, moveUpSav},
             XspeedSav, YspeedSav, stopSaviorSignal, state_dbg_o};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL chk%0d: output presented with no expectation queued", n_cmp);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_bad++;
          $display("FAIL chk%0d: got x=%0d y=%0d flg=%b xs=%0d ys=%0d stop=%b st=%0d, want x=%0d y=%0d flg=%b xs=%0d ys=%0d stop=%b st=%0d",
                   n_cmp, act.x, act.y, act.flg, act.xs, act.ys, act.stp, act.st,
                   e.x, e.y, e.flg, e.xs, e.ys, e.stp, e.st);
        end
      end
    end
  end

  // driver tasks
  task automatic push_exp(input int x, input int y, input logic [2:0] flg, input int xs,
                          input int ys, input logic [3:0] stp, input state_t st);
    obs_t e;
    e.x = 11'(x); e.y = 11'(y); e.flg = flg; e.xs = 11'(xs); e.ys = 11'(ys);
    e.stp = stp; e.st = st;
    exp_q.push_back(e);
  endtask

  task automatic frame();
    @(negedge clk); startOfFrame = 1'b1;
    @(negedge clk); startOfFrame = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_now();
    @(negedge clk); chk_req = 1'b1;
    @(negedge clk); chk_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic bump(input logic [3:0] code);
    @(negedge clk); collisionSavBorder = 1'b1; HitEdgeCode = code;
    @(negedge clk); collisionSavBorder = 1'b0; HitEdgeCode = '0;
  endtask

  int xs_tab[10] = '{64, 80, 96, 112, 128, 144, 160, 176, 192, 192};
  int px_tab[10] = '{101, 102, 103, 105, 107, 109, 112, 115, 118, 121};

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    push_exp(100, 200, F_NONE, 0, 0, 4'b0000, IDLE);
    check_now();

    // Right ramp up to saturation (truncating pixel conversion)
    btnRight = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_exp(px_tab[i], 200, F_R, xs_tab[i], 0, 4'b0000, MOVE);
      frame();
    end
    btnRight = 1'b0;
    push_exp(121, 200, F_NONE, 0, 0, 4'b0000, IDLE);
    frame();

    // Down, then Left takes priority and speed reloads
    btnDown = 1'b1;
    push_exp(121, 201, F_D, 0, 64, 4'b0000, MOVE);
    frame();
    btnLeft = 1'b1;
    push_exp(120, 201, F_L, 64, 0, 4'b0000, MOVE);
    frame();
    btnDown = 1'b0;

    // A hit on a non-leading edge is ignored
    bump(4'b0111);
    push_exp(118, 201, F_L, 80, 0, 4'b0000, MOVE);
    frame();

    // Left-edge hit: back off 1 px, report block, hold while still pushing left
    bump(4'b1000);
    push_exp(119, 201, F_L, 0, 0, 4'b1000, BLOCKED);
    frame();
    push_exp(119, 201, F_L, 0, 0, 4'b1000, BLOCKED);
    frame();

    // Switching to right clears the block
    btnLeft = 1'b0; btnRight = 1'b1;
    push_exp(120, 201, F_R, 64, 0, 4'b0000, MOVE);
    frame();

    // Up into a key-side stop, stays blocked after the stop drops
    btnRight = 1'b0; btnUp = 1'b1; stopKeySignal = 4'b0001;
    push_exp(120, 201, F_U, 0, 0, 4'b0000, BLOCKED);
    frame();
    stopKeySignal = 4'b0000;
    push_exp(120, 201, F_U, 0, 0, 4'b0000, BLOCKED);
    frame();
    btnUp = 1'b0;
    push_exp(120, 201, F_NONE, 0, 0, 4'b0000, IDLE);
    frame();
    btnUp = 1'b1;
    push_exp(120, 200, F_U, 0, 64, 4'b0000, MOVE);
    frame();

    // Level restart coincident with SOF wins over movement
    @(negedge clk); startLevel2 = 1'b1; startOfFrame = 1'b1;
    push_exp(100, 200, F_NONE, 0, 0, 4'b0000, IDLE);
    @(negedge clk); startLevel2 = 1'b0; startOfFrame = 1'b0;
    repeat (2) @(negedge clk);
    push_exp(100, 199, F_U, 0, 64, 4'b0000, MOVE);
    frame();

    // Level 3 restart outside a frame
    btnUp = 1'b0;
    push_exp(100, 200, F_NONE, 0, 0, 4'b0000, IDLE);
    @(negedge clk); startLevel3 = 1'b1; chk_req = 1'b1;
    @(negedge clk); startLevel3 = 1'b0; chk_req = 1'b0;
    repeat (4) @(negedge clk);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover: got %0d unchecked expectations, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
